// File: rtl/bpi_cmd_sequencer_if.sv
// Bus-side connection between the command sequencer and bpi_interface.
//   master : sequencer side (drives address, command/data, op, execute)
//   slave  : bpi_interface side (drives read data, load strobe, busy)
//   BPI_ADDR      23  word/block address of the bus cycle
//   BPI_CMD_DATA  16  command or program data for write cycles
//   BPI_OP         2  01 write, 10 read, 00 idle
//   BPI_EXECUTE    1  one-cycle strobe starting a bus cycle
//   BPI_DATA_IN   16  read data
//   BPI_LOAD_DATA  1  BPI_DATA_IN valid this cycle
//   BPI_BUSY       1  bus cycle in progress
interface bpi_cmd_sequencer_if;
  logic [22:0] BPI_ADDR;
  logic [15:0] BPI_CMD_DATA;
  logic [1:0]  BPI_OP;
  logic        BPI_EXECUTE;
  logic [15:0] BPI_DATA_IN;
  logic        BPI_LOAD_DATA;
  logic        BPI_BUSY;

  modport master (
    output BPI_ADDR, BPI_CMD_DATA, BPI_OP, BPI_EXECUTE,
    input  BPI_DATA_IN, BPI_LOAD_DATA, BPI_BUSY
  );

  modport slave (
    input  BPI_ADDR, BPI_CMD_DATA, BPI_OP, BPI_EXECUTE,
    output BPI_DATA_IN, BPI_LOAD_DATA, BPI_BUSY
  );
endinterface

// File: rtl/bpi_cmd_sequencer.sv
// Turns one flash request (read, status, clear, unlock, program, erase,
// read-array) into the sequence of single bus cycles run by bpi_interface,
// including status polling with timeout and the trailing read-array write.
//   CLK, RST_B       clock, synchronous active-low reset
//   START/OPC/ADDR/WDATA  request strobe, opcode, address, program data
//   RDY, DONE        idle/accepting, one-cycle completion pulse
//   RDATA, STATUS    last word read, last status register value
//   ERR              00 ok, 01 SR error, 10 timeout, 11 illegal opcode
//   bpi              bus-side interface (master modport)
//
// state  | meaning
// IDLE   | waiting for START, RDY=1
// ISSUE  | BPI_EXECUTE=1 for one cycle, bus outputs valid
// GUARD  | GUARD cycles where BPI_BUSY is not yet trustworthy
// WAIT   | waiting for BPI_BUSY=0
// NEXT   | advance step or evaluate poll result
// FINISH | DONE=1 for one cycle
module bpi_cmd_sequencer #(
  parameter int unsigned MAX_POLLS = 65535,
  parameter int unsigned GUARD     = 2
) (
  input  logic                CLK,
  input  logic                RST_B,
  input  logic                START,
  input  logic [2:0]          OPC,
  input  logic [22:0]         ADDR,
  input  logic [15:0]         WDATA,
  output logic                RDY,
  output logic                DONE,
  output logic [15:0]         RDATA,
  output logic [7:0]          STATUS,
  output logic [1:0]          ERR,
  bpi_cmd_sequencer_if.master bpi
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_NEXT, S_FINISH} state_t;
  typedef enum logic [1:0] {K_WRITE, K_READ, K_POLL, K_END} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [15:0] word;
  } step_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  // Command table: what bus cycle step <step> of opcode <opc> is.
  function automatic step_t decode(input logic [2:0] opc, input logic [2:0] step,
                                   input logic [15:0] wdata);
    step_t d;
    d.kind = K_END;
    d.word = 16'h0000;
    case (opc)
      3'd0: if (step == 3'd0) d.kind = K_READ;
      3'd1: case (step)
              3'd0: begin d.kind = K_WRITE; d.word = 16'h0070; end
              3'd1: d.kind = K_READ;
              default: ;
            endcase
      3'd2: if (step == 3'd0) begin d.kind = K_WRITE; d.word = 16'h0050; end
      3'd3: case (step)
              3'd0: begin d.kind = K_WRITE; d.word = 16'h0060; end
              3'd1: begin d.kind = K_WRITE; d.word = 16'h00D0; end
              default: ;
            endcase
      3'd4, 3'd5: case (step)
              3'd0: begin d.kind = K_WRITE; d.word = (opc == 3'd4) ? 16'h0040 : 16'h0020; end
              3'd1: begin d.kind = K_WRITE; d.word = (opc == 3'd4) ? wdata : 16'h00D0; end
              3'd2: d.kind = K_POLL;
              3'd3: begin d.kind = K_WRITE; d.word = 16'h00FF; end
              default: ;
            endcase
      3'd6: if (step == 3'd0) begin d.kind = K_WRITE; d.word = 16'h00FF; end
      default: ;
    endcase
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  opc_q, opc_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  err_q, err_d;
  logic [22:0] bpi_addr_q, bpi_addr_d;
  logic [15:0] bpi_cmd_q, bpi_cmd_d;
  logic [1:0]  bpi_op_q, bpi_op_d;

  step_t       cur, nxt;
  logic        load_bus;
  logic [22:0] bus_addr;
  logic [2:0]  step_n;
  logic [16:0] polls_done;

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    step_d      = step_q;
    poll_cnt_d  = poll_cnt_q;
    guard_cnt_d = guard_cnt_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    err_d       = err_q;
    bpi_addr_d  = bpi_addr_q;
    bpi_cmd_d   = bpi_cmd_q;
    bpi_op_d    = bpi_op_q;
    cur         = decode(opc_q, step_q, wdata_q);
    nxt         = cur;
    load_bus    = 1'b0;
    bus_addr    = addr_q;
    step_n      = step_q;
    polls_done  = {1'b0, poll_cnt_q} + 17'd1;

    unique case (state_q)
      S_IDLE: if (START) begin
        opc_d      = OPC;
        addr_d     = ADDR;
        wdata_d    = WDATA;
        step_d     = 3'd0;
        poll_cnt_d = 16'd0;
        err_d      = (OPC == 3'd7) ? 2'b11 : 2'b00;
        nxt        = decode(OPC, 3'd0, WDATA);
        // Illegal opcode has no bus cycles; NEXT resolves it to FINISH.
        if (nxt.kind == K_END) state_d = S_NEXT;
        else begin
          state_d  = S_ISSUE;
          load_bus = 1'b1;
          bus_addr = ADDR;
        end
      end
      S_ISSUE: begin
        if (GUARD == 0) state_d = S_WAIT;
        else begin
          state_d     = S_GUARD;
          guard_cnt_d = 8'(GUARD - 1);
        end
      end
      S_GUARD: begin
        if (guard_cnt_q == 8'd0) state_d = S_WAIT;
        else guard_cnt_d = guard_cnt_q - 8'd1;
      end
      S_WAIT: if (!bpi.BPI_BUSY) state_d = S_NEXT;
      S_NEXT: begin
        step_n = step_q + 3'd1;
        if (cur.kind == K_POLL) begin
          if (poll_cnt_q != 16'hFFFF) poll_cnt_d = poll_cnt_q + 16'd1;
          // SR7 (ready) takes priority over the poll limit.
          if (status_q[7]) begin
            if ((status_q & 8'h3A) != 8'h00) err_d = 2'b01;
          end else if (polls_done < 17'(MAX_POLLS)) begin
            step_n = step_q;
          end else begin
            err_d = 2'b10;
          end
        end
        step_d = step_n;
        nxt    = decode(opc_q, step_n, wdata_q);
        if (nxt.kind == K_END) state_d = S_FINISH;
        else begin
          state_d  = S_ISSUE;
          load_bus = 1'b1;
        end
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        bpi_op_d = OP_NONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reads leave BPI_CMD_DATA at its previous value.
    if (load_bus) begin
      bpi_addr_d = bus_addr;
      bpi_op_d   = (nxt.kind == K_WRITE) ? OP_WR : OP_RD;
      if (nxt.kind == K_WRITE) bpi_cmd_d = nxt.word;
    end

    if ((state_q == S_ISSUE || state_q == S_GUARD || state_q == S_WAIT) &&
        bpi_op_q == OP_RD && bpi.BPI_LOAD_DATA) begin
      case (cur.kind)
        K_READ: begin
          if (opc_q == 3'd1) begin
            status_d = bpi.BPI_DATA_IN[7:0];
            rdata_d  = {8'h00, bpi.BPI_DATA_IN[7:0]};
          end else begin
            rdata_d  = bpi.BPI_DATA_IN;
          end
        end
        K_POLL:  status_d = bpi.BPI_DATA_IN[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q     <= S_IDLE;
      opc_q       <= 3'd0;
      addr_q      <= 23'd0;
      wdata_q     <= 16'd0;
      step_q      <= 3'd0;
      poll_cnt_q  <= 16'd0;
      guard_cnt_q <= 8'd0;
      rdata_q     <= 16'd0;
      status_q    <= 8'h80;
      err_q       <= 2'b00;
      bpi_addr_q  <= 23'd0;
      bpi_cmd_q   <= 16'd0;
      bpi_op_q    <= OP_NONE;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      step_q      <= step_d;
      poll_cnt_q  <= poll_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      err_q       <= err_d;
      bpi_addr_q  <= bpi_addr_d;
      bpi_cmd_q   <= bpi_cmd_d;
      bpi_op_q    <= bpi_op_d;
    end
  end

  assign RDY              = (state_q == S_IDLE);
  assign DONE             = (state_q == S_FINISH);
  assign RDATA            = rdata_q;
  assign STATUS           = status_q;
  assign ERR              = err_q;
  assign bpi.BPI_EXECUTE  = (state_q == S_ISSUE);
  assign bpi.BPI_ADDR     = bpi_addr_q;
  assign bpi.BPI_CMD_DATA = bpi_cmd_q;
  assign bpi.BPI_OP       = bpi_op_q;

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
module tb_bpi_cmd_sequencer;
  localparam int MAXP = 4;

  logic        CLK = 1'b0;
  logic        RST_B = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OPC = 3'd0;
  logic [22:0] ADDR = 23'd0;
  logic [15:0] WDATA = 16'd0;
  logic        RDY, DONE;
  logic [15:0] RDATA;
  logic [7:0]  STATUS;
  logic [1:0]  ERR;

  bpi_cmd_sequencer_if bus();

  bpi_cmd_sequencer #(.MAX_POLLS(MAXP), .GUARD(2)) dut (
    .CLK(CLK), .RST_B(RST_B), .START(START), .OPC(OPC), .ADDR(ADDR), .WDATA(WDATA),
    .RDY(RDY), .DONE(DONE), .RDATA(RDATA), .STATUS(STATUS), .ERR(ERR), .bpi(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  op;
    logic [22:0] addr;
    logic [15:0] data;
    logic        chk;
  } bus_t;
  typedef struct packed {
    logic [1:0]  err;
    logic [15:0] rdata;
    logic [7:0]  status;
  } res_t;

  bus_t        exp_bus[$];
  res_t        exp_res[$];
  logic [15:0] rd_plan[$];
  int checks = 0, errors = 0, done_count = 0, exec_count = 0;
  logic [15:0] m_rdata = 16'h0000;
  logic [7:0]  m_status = 8'h80;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [22:0] a, input logic [15:0] d);
    exp_bus.push_back('{op: 2'b01, addr: a, data: d, chk: 1'b1});
  endtask

  task automatic exp_rd(input logic [22:0] a, input logic [15:0] d);
    exp_bus.push_back('{op: 2'b10, addr: a, data: 16'h0000, chk: 1'b0});
    rd_plan.push_back(d);
  endtask

  // Reference model: expected bus trace, flash read data, and final result.
  // Polls return nr_sr (SR7 forced 0) n_busy times, then final_sr with SR7 set.
  task automatic plan_request(input logic [2:0] opc, input logic [22:0] a,
                              input logic [15:0] wd, input int n_busy,
                              input logic [7:0] nr_sr, input logic [7:0] final_sr,
                              input logic [7:0] hi);
    res_t r;
    logic [7:0] sr;
    logic [15:0] w;
    r.err = 2'b00;
    case (opc)
      3'd0: begin w = 16'($urandom); exp_rd(a, w); m_rdata = w; end
      3'd1: begin
        exp_wr(a, 16'h0070); exp_rd(a, {hi, final_sr});
        m_status = final_sr; m_rdata = {8'h00, final_sr};
      end
      3'd2: exp_wr(a, 16'h0050);
      3'd3: begin exp_wr(a, 16'h0060); exp_wr(a, 16'h00D0); end
      3'd4, 3'd5: begin
        if (opc == 3'd4) begin exp_wr(a, 16'h0040); exp_wr(a, wd); end
        else begin exp_wr(a, 16'h0020); exp_wr(a, 16'h00D0); end
        for (int i = 0; i < MAXP; i++) begin
          sr = (i < n_busy) ? (nr_sr & 8'h7F) : (final_sr | 8'h80);
          exp_rd(a, {hi, sr});
          m_status = sr;
          if (sr[7]) begin
            if ((sr & 8'h3A) != 8'h00) r.err = 2'b01;
            break;
          end
          if (i == MAXP - 1) r.err = 2'b10;
        end
        exp_wr(a, 16'h00FF);
      end
      3'd6: exp_wr(a, 16'h00FF);
      default: r.err = 2'b11;
    endcase
    r.rdata = m_rdata;
    r.status = m_status;
    exp_res.push_back(r);
  endtask

  task automatic start_req(input logic [2:0] opc, input logic [22:0] a, input logic [15:0] wd);
    @(negedge CLK);
    START = 1'b1; OPC = opc; ADDR = a; WDATA = wd;
    @(negedge CLK);
    START = 1'b0; OPC = 3'($urandom); ADDR = 23'($urandom); WDATA = 16'($urandom);
    chk("rdy_drops", RDY, 0);
    chk("first_execute", bus.BPI_EXECUTE, (opc != 3'd7) ? 1 : 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (RDY !== 1'b1 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    chk("request_completes", RDY, 1);
  endtask

  task automatic run_req(input logic [2:0] opc, input logic [22:0] a, input logic [15:0] wd,
                         input int n_busy, input logic [7:0] nr_sr,
                         input logic [7:0] final_sr, input logic [7:0] hi);
    plan_request(opc, a, wd, n_busy, nr_sr, final_sr, hi);
    start_req(opc, a, wd);
    wait_idle();
  endtask

  // Flash / bpi_interface model: busy for 1..4 cycles, read data on last busy cycle.
  initial begin
    int n;
    logic is_rd;
    logic [15:0] d;
    bus.BPI_BUSY = 1'b0; bus.BPI_LOAD_DATA = 1'b0; bus.BPI_DATA_IN = 16'h0000;
    forever begin
      @(negedge CLK);
      if (bus.BPI_EXECUTE === 1'b1) begin
        n = $urandom_range(1, 4);
        is_rd = (bus.BPI_OP == 2'b10);
        d = 16'h0000;
        if (is_rd && rd_plan.size() > 0) d = rd_plan.pop_front();
        @(negedge CLK);
        bus.BPI_BUSY = 1'b1;
        repeat (n - 1) @(negedge CLK);
        if (is_rd) begin bus.BPI_LOAD_DATA = 1'b1; bus.BPI_DATA_IN = d; end
        @(negedge CLK);
        bus.BPI_BUSY = 1'b0; bus.BPI_LOAD_DATA = 1'b0;
      end
    end
  end

  // Bus monitor
  initial begin
    bus_t e;
    logic prev_exec;
    prev_exec = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.BPI_EXECUTE === 1'b1) begin
        exec_count++;
        chk("exec_pulse_width", prev_exec, 0);
        chk("exec_while_busy", bus.BPI_BUSY, 0);
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_cycle: got op %0h addr 0x%0h, expected no bus cycle",
                   bus.BPI_OP, bus.BPI_ADDR);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_op", bus.BPI_OP, e.op);
          chk("bus_addr", bus.BPI_ADDR, e.addr);
          if (e.chk) chk("bus_data", bus.BPI_CMD_DATA, e.data);
        end
      end
      prev_exec = bus.BPI_EXECUTE;
    end
  end

  // Result monitor
  initial begin
    res_t r;
    forever begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        done_count++;
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got DONE with ERR %0h, expected no DONE", ERR);
        end else begin
          r = exp_res.pop_front();
          chk("err", ERR, r.err);
          chk("rdata", RDATA, r.rdata);
          chk("status", STATUS, r.status);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k, d0;
    RST_B = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_rdy", RDY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_rdata", RDATA, 16'h0000);
    chk("rst_status", STATUS, 8'h80);
    chk("rst_err", ERR, 2'b00);
    chk("rst_execute", bus.BPI_EXECUTE, 0);
    chk("rst_op", bus.BPI_OP, 2'b00);
    chk("rst_addr", bus.BPI_ADDR, 23'd0);
    chk("rst_cmd", bus.BPI_CMD_DATA, 16'd0);
    RST_B = 1'b1;
    @(negedge CLK);

    run_req(3'd1, 23'h000100, 16'h0000, 0, 8'h00, 8'h80, 8'h00);
    run_req(3'd4, 23'h012345, 16'hA5C3, 2, 8'h00, 8'h80, 8'h5A);
    run_req(3'd5, 23'h040000, 16'h0000, 0, 8'h00, 8'hA2, 8'h00);
    chk("op_idle_after_req", bus.BPI_OP, 2'b00);

    // Timeout, with a START pulse that must be ignored mid-sequence.
    plan_request(3'd4, 23'h0ABCDE, 16'h1234, 10, 8'h00, 8'h80, 8'h00);
    start_req(3'd4, 23'h0ABCDE, 16'h1234);
    repeat (6) @(negedge CLK);
    START = 1'b1; OPC = 3'd2; ADDR = 23'h7FFFFF;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();

    // Illegal opcode: DONE two cycles after START, no bus cycles.
    plan_request(3'd7, 23'h001000, 16'h0000, 0, 8'h00, 8'h80, 8'h00);
    start_req(3'd7, 23'h001000, 16'h0000);
    chk("illegal_done_early", DONE, 0);
    @(negedge CLK);
    chk("illegal_done_2cyc", DONE, 1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      run_req(3'($urandom_range(0, 7)), 23'($urandom), 16'($urandom),
              $urandom_range(0, 5), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // Reset during erase poll.
    plan_request(3'd5, 23'h055555, 16'h0000, 10, 8'h00, 8'h80, 8'h00);
    base = exec_count;
    start_req(3'd5, 23'h055555, 16'h0000);
    k = 0;
    while (exec_count < base + 3 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("abort_reached_poll", (exec_count >= base + 3) ? 1 : 0, 1);
    @(negedge CLK);
    d0 = done_count;
    RST_B = 1'b0;
    @(negedge CLK);
    chk("abort_op", bus.BPI_OP, 2'b00);
    chk("abort_rdy", RDY, 1);
    chk("abort_execute", bus.BPI_EXECUTE, 0);
    chk("abort_status", STATUS, 8'h80);
    RST_B = 1'b1;
    exp_bus.delete();
    rd_plan.delete();
    void'(exp_res.pop_back());
    m_status = 8'h80;
    m_rdata = 16'h0000;
    repeat (15) @(negedge CLK);
    chk("abort_no_done", done_count, d0);
    chk("abort_no_bus", exp_bus.size(), 0);

    run_req(3'd1, 23'h000200, 16'h0000, 0, 8'h00, 8'h90, 8'h33);
    run_req(3'd6, 23'h000000, 16'h0000, 0, 8'h00, 8'h80, 8'h00);

    repeat (5) @(negedge CLK);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
